// File: rtl/simon_round_ctrl_if.sv
// Signal bundle between the Simon round controller, its host wrapper and the round datapath.
// The slave view belongs to the controller; the master view to whatever surrounds it.
interface simon_round_ctrl_if;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [127:0] pt_i;
    logic [127:0] key_i;
    logic         rnd_en_o;
    logic [127:0] rnd_pt_o;
    logic [63:0]  rnd_key_o;
    logic [127:0] rnd_ct_i;
    logic [6:0]   round_o;
    logic         busy_o;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [127:0] ct_o;

    modport slave (
        input  in_valid_i, pt_i, key_i, rnd_ct_i, out_ready_i,
        output in_ready_o, rnd_en_o, rnd_pt_o, rnd_key_o, round_o, busy_o, out_valid_o, ct_o
    );

    modport master (
        output in_valid_i, pt_i, key_i, rnd_ct_i, out_ready_i,
        input  in_ready_o, rnd_en_o, rnd_pt_o, rnd_key_o, round_o, busy_o, out_valid_o, ct_o
    );
endinterface

// File: rtl/simon_round_ctrl.sv
// Sequencer for one iterative Simon 128/128 round datapath: accepts a block, runs the
// m=2 key schedule on the fly for ROUNDS iterations and returns the captured ciphertext.
module simon_round_ctrl #(
    parameter int unsigned ROUNDS = 68,
    parameter logic [61:0] Z_SEQ  = 62'b10101111011100000011010010011000101000010001111110010110110011
) (
    input  logic              clk,
    input  logic              rst,
    simon_round_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_CAPTURE,
        S_OUT
    } state_e;

    localparam logic [6:0]  LAST_ROUND = 7'(ROUNDS - 1);
    localparam logic [63:0] KS_CONST   = 64'hFFFF_FFFF_FFFF_FFFC;

    state_e       state_q, state_d;
    logic [127:0] pt_q, pt_d;
    logic [127:0] ct_q, ct_d;
    logic [63:0]  ka_q, ka_d;
    logic [63:0]  kb_q, kb_d;
    logic [6:0]   round_q, round_d;
    logic [5:0]   z_idx;
    logic         z_bit;
    logic [63:0]  kb_ror3;
    logic [63:0]  kb_ror4;

    // The z2 sequence repeats every 62 rounds; bit 0 is the leftmost character of Z_SEQ.
    assign z_idx   = (round_q >= 7'd62) ? 6'(round_q - 7'd62) : round_q[5:0];
    assign z_bit   = Z_SEQ[6'd61 - z_idx];
    assign kb_ror3 = {kb_q[2:0], kb_q[63:3]};
    assign kb_ror4 = {kb_q[3:0], kb_q[63:4]};

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        pt_d    = pt_q;
        ct_d    = ct_q;
        ka_d    = ka_q;
        kb_d    = kb_q;
        round_d = round_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid_i) begin
                    pt_d    = bus.pt_i;
                    ka_d    = bus.key_i[63:0];
                    kb_d    = bus.key_i[127:64];
                    round_d = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_ROUND;
            end
            S_ROUND: begin
                ka_d    = kb_q;
                kb_d    = KS_CONST ^ {63'b0, z_bit} ^ ka_q ^ kb_ror3 ^ kb_ror4;
                round_d = round_q + 7'd1;
                if (round_q == LAST_ROUND) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // The datapath still holds the final round state during this cycle.
                ct_d    = bus.rnd_ct_i;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pt_q    <= '0;
            ct_q    <= '0;
            ka_q    <= '0;
            kb_q    <= '0;
            round_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values.
            state_q <= state_d;
            pt_q    <= pt_d;
            ct_q    <= ct_d;
            ka_q    <= ka_d;
            kb_q    <= kb_d;
            round_q <= round_d;
        end
    end

    assign bus.in_ready_o  = (state_q == S_IDLE);
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.rnd_en_o    = (state_q == S_ROUND);
    assign bus.out_valid_o = (state_q == S_OUT);
    assign bus.rnd_pt_o    = pt_q;
    assign bus.rnd_key_o   = ka_q;
    assign bus.round_o     = round_q;
    assign bus.ct_o        = ct_q;
endmodule

// File: tb/tb_simon_round_ctrl.sv
// Bench for simon_round_ctrl: behavioural round datapath, spec-level Simon reference model,
// vector table plus hand-written backpressure, back-to-back, reset and reduced-round cases.
module tb_simon_round_ctrl;
    localparam int R = 68;
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [127:0] KAT_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] KAT_PT  = 128'h6373656420737265_6c6c657661727420;
    localparam logic [127:0] KAT_CT  = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    simon_round_ctrl_if bus();
    simon_round_ctrl_if bus1();

    simon_round_ctrl #(.ROUNDS(R)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
    simon_round_ctrl #(.ROUNDS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    function automatic logic [63:0] rotl(input logic [63:0] v, input int n);
        return (v << n) | (v >> (64 - n));
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [63:0] simon_f(input logic [63:0] x);
        return (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2);
    endfunction

    function automatic logic [127:0] simon_rnd(input logic [127:0] s, input logic [63:0] k);
        return {s[63:0] ^ simon_f(s[127:64]) ^ k, s[127:64]};
    endfunction

    // Key schedule as written in the Simon paper: k[i+2] = ~k[i] ^ (I ^ S^-1) S^-3 k[i+1] ^ z ^ 3.
    function automatic logic [63:0] ref_key(input logic [127:0] key, input int j);
        logic [63:0] k [0:69];
        logic [61:0] z;
        logic [63:0] t;
        z    = Z2;
        k[0] = key[63:0];
        k[1] = key[127:64];
        for (int i = 0; i + 2 <= j; i++) begin
            t        = rotr(k[i+1], 3);
            t        = t ^ rotr(t, 1);
            k[i+2]   = ~k[i] ^ t ^ 64'(z[61 - (i % 62)]) ^ 64'd3;
        end
        return k[j];
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key, input int rounds);
        logic [63:0] x, y, t;
        x = pt[127:64];
        y = pt[63:0];
        for (int r = 0; r < rounds; r++) begin
            t = x;
            x = y ^ simon_f(x) ^ ref_key(key, r);
            y = t;
        end
        return {x, y};
    endfunction

    // Stand-in for rodada_simon: load when disabled, one round per enabled edge.
    logic [127:0] rd_q, rd1_q;
    always @(posedge clk) begin
        rd_q  <= bus.rnd_en_o  ? simon_rnd(rd_q,  bus.rnd_key_o)  : bus.rnd_pt_o;
        rd1_q <= bus1.rnd_en_o ? simon_rnd(rd1_q, bus1.rnd_key_o) : bus1.rnd_pt_o;
    end
    assign bus.rnd_ct_i  = rd_q;
    assign bus1.rnd_ct_i = rd1_q;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one block while in IDLE; returns in the LOAD cycle (cycle 1).
    task automatic send(input logic [127:0] key, input logic [127:0] pt);
        bus.key_i      = key;
        bus.pt_i       = pt;
        bus.in_valid_i = 1'b1;
        tick();
        bus.in_valid_i = 1'b0;
        check_bit("accept_busy", bus.busy_o, 1'b1);
    endtask

    // Called in cycle 1; counts cycles until out_valid_o, optionally checking every round key.
    task automatic wait_out(input logic [127:0] key, input bit chk, output int lat);
        int cyc;
        cyc = 1;
        while (!bus.out_valid_o && cyc < 300) begin
            if (chk) begin
                check_bit("rnd_en", bus.rnd_en_o, (cyc >= 2 && cyc <= R + 1));
                if (cyc >= 2 && cyc <= R + 1) begin
                    check("rnd_key", {64'd0, bus.rnd_key_o}, {64'd0, ref_key(key, cyc - 2)});
                    check_int("round_o", int'(bus.round_o), cyc - 2);
                end
            end
            tick();
            cyc++;
        end
        lat = cyc;
    endtask

    task automatic run1(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] exp);
        int lat;
        bus1.key_i      = key;
        bus1.pt_i       = pt;
        bus1.in_valid_i = 1'b1;
        tick();
        bus1.in_valid_i = 1'b0;
        lat = 1;
        while (!bus1.out_valid_o && lat < 50) begin
            tick();
            lat++;
        end
        check_int("r1_latency", lat, 4);
        check("r1_ct", bus1.ct_o, exp);
        tick();
        check_bit("r1_idle", bus1.in_ready_o, 1'b1);
    endtask

    typedef struct packed {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        int hold;
        int cnt;
        logic [127:0] key, pt, exp, key_b, pt_b;

        vecs[0] = '{key: KAT_KEY, pt: KAT_PT, ct: KAT_CT};
        vecs[1] = '{key: '0, pt: '0, ct: ref_encrypt('0, '0, R)};
        vecs[2] = '{key: '1, pt: '1, ct: ref_encrypt('1, '1, R)};
        key = {$urandom, $urandom, $urandom, $urandom};
        pt  = {$urandom, $urandom, $urandom, $urandom};
        vecs[3] = '{key: key, pt: pt, ct: ref_encrypt(pt, key, R)};

        rst              = 1'b1;
        bus.in_valid_i   = 1'b0;
        bus.pt_i         = '0;
        bus.key_i        = '0;
        bus.out_ready_i  = 1'b1;
        bus1.in_valid_i  = 1'b0;
        bus1.pt_i        = '0;
        bus1.key_i       = '0;
        bus1.out_ready_i = 1'b1;
        repeat (3) tick();

        check_bit("rst_in_ready", bus.in_ready_o, 1'b1);
        check_bit("rst_busy", bus.busy_o, 1'b0);
        check_bit("rst_out_valid", bus.out_valid_o, 1'b0);
        check_bit("rst_rnd_en", bus.rnd_en_o, 1'b0);
        check("rst_ct", bus.ct_o, '0);
        check("rst_rnd_pt", bus.rnd_pt_o, '0);
        check("rst_rnd_key", {64'd0, bus.rnd_key_o}, '0);
        check_int("rst_round", int'(bus.round_o), 0);
        rst = 1'b0;
        tick();

        // Table of blocks with full key-schedule and latency checking.
        for (int v = 0; v < 4; v++) begin
            send(vecs[v].key, vecs[v].pt);
            wait_out(vecs[v].key, 1'b1, lat);
            check_int("latency", lat, R + 3);
            check("ct", bus.ct_o, vecs[v].ct);
            tick();
            check_bit("back_to_idle", bus.in_ready_o, 1'b1);
            check_bit("idle_out_valid", bus.out_valid_o, 1'b0);
        end

        // Random blocks with short random output backpressure.
        for (int r = 0; r < 4; r++) begin
            key  = {$urandom, $urandom, $urandom, $urandom};
            pt   = {$urandom, $urandom, $urandom, $urandom};
            exp  = ref_encrypt(pt, key, R);
            hold = int'($urandom_range(0, 3));
            bus.out_ready_i = (hold == 0);
            send(key, pt);
            wait_out(key, 1'b0, lat);
            check_int("rand_latency", lat, R + 3);
            check("rand_ct", bus.ct_o, exp);
            for (int h = 0; h < hold; h++) begin
                tick();
                check_bit("rand_hold_valid", bus.out_valid_o, 1'b1);
                check("rand_hold_ct", bus.ct_o, exp);
            end
            bus.out_ready_i = 1'b1;
            tick();
            check_bit("rand_idle", bus.in_ready_o, 1'b1);
        end

        // Long backpressure with an in_valid pulse that must be ignored.
        bus.out_ready_i = 1'b0;
        send(KAT_KEY, KAT_PT);
        wait_out(KAT_KEY, 1'b0, lat);
        check_int("bp_latency", lat, R + 3);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                bus.in_valid_i = 1'b1;
                bus.pt_i       = '1;
                bus.key_i      = '1;
            end
            tick();
            bus.in_valid_i = 1'b0;
            check_bit("bp_valid", bus.out_valid_o, 1'b1);
            check("bp_ct", bus.ct_o, KAT_CT);
            check_bit("bp_in_ready", bus.in_ready_o, 1'b0);
        end
        bus.out_ready_i = 1'b1;
        tick();
        check_bit("bp_idle_ready", bus.in_ready_o, 1'b1);
        check_bit("bp_idle_valid", bus.out_valid_o, 1'b0);
        repeat (3) tick();
        check_bit("bp_pulse_ignored", bus.busy_o, 1'b0);

        // Back-to-back: in_valid stays high, second block is taken in the IDLE cycle after OUT.
        key_b = {$urandom, $urandom, $urandom, $urandom};
        pt_b  = {$urandom, $urandom, $urandom, $urandom};
        bus.key_i      = KAT_KEY;
        bus.pt_i       = KAT_PT;
        bus.in_valid_i = 1'b1;
        tick();
        bus.key_i = key_b;
        bus.pt_i  = pt_b;
        wait_out(KAT_KEY, 1'b1, lat);
        check_int("b2b_latency_a", lat, R + 3);
        check("b2b_ct_a", bus.ct_o, KAT_CT);
        tick();
        cnt = 1;
        check_bit("b2b_gap_valid", bus.out_valid_o, 1'b0);
        check_bit("b2b_gap_ready", bus.in_ready_o, 1'b1);
        while (!bus.out_valid_o && cnt < 300) begin
            tick();
            cnt++;
            if (cnt == 2) bus.in_valid_i = 1'b0;
        end
        bus.in_valid_i = 1'b0;
        check_int("b2b_spacing", cnt, R + 4);
        check("b2b_ct_b", bus.ct_o, ref_encrypt(pt_b, key_b, R));
        tick();

        // Reset in round 30 aborts the block; a fresh known-answer run must still work.
        send(KAT_KEY, KAT_PT);
        repeat (31) tick();
        check_int("mid_round_index", int'(bus.round_o), 30);
        rst = 1'b1;
        tick();
        check_bit("mid_rst_valid", bus.out_valid_o, 1'b0);
        check_bit("mid_rst_ready", bus.in_ready_o, 1'b1);
        check_bit("mid_rst_en", bus.rnd_en_o, 1'b0);
        check("mid_rst_ct", bus.ct_o, '0);
        rst = 1'b0;
        tick();
        send(KAT_KEY, KAT_PT);
        wait_out(KAT_KEY, 1'b1, lat);
        check_int("post_rst_latency", lat, R + 3);
        check("post_rst_ct", bus.ct_o, KAT_CT);
        tick();

        // Single-round instance.
        run1('0, '0, '0);
        key = {$urandom, $urandom, $urandom, $urandom};
        pt  = {$urandom, $urandom, $urandom, $urandom};
        run1(key, pt, ref_encrypt(pt, key, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
